// File: rtl/axis_addone_arbiter.sv
// Two-requester AXI4-Stream round-robin arbiter feeding one add-one core; the grant is held for a whole packet.
// Optional per-source accepted-packet counters are enabled by defining ARB_STATS_EN.
module axis_addone_arbiter #(
  parameter int  DATA_WIDTH = 32,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tdest,
  output logic [1:0]            grant
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t st_r;
  state_t st_nxt_s;
  logic   lg_r;
  logic   lg_nxt_s;
  logic   acc_s;
  logic   pkt_end_s;

  // On a tie the requester that did not own the previous packet wins.
  function automatic state_t arb(input logic v0, input logic v1, input logic lg);
    state_t res;
    if (v0 && v1) begin
      if (lg) begin
        res = G0;
      end else begin
        res = G1;
      end
    end else if (v0) begin
      res = G0;
    end else if (v1) begin
      res = G1;
    end else begin
      res = IDLE;
    end
    return res;
  endfunction

  assign acc_s     = m_axis_tvalid & m_axis_tready;
  assign pkt_end_s = acc_s & m_axis_tlast;

  // Zero-latency output mux steered by the current owner.
  always_comb begin
    m_axis_tdata   = {DATA_WIDTH{1'b0}};
    m_axis_tkeep   = {KEEP_WIDTH{1'b0}};
    m_axis_tlast   = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdest   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;
    case (st_r)
      G0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdest   = 1'b0;
        s0_axis_tready = m_axis_tready;
        grant          = 2'b01;
      end
      G1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdest   = 1'b1;
        s1_axis_tready = m_axis_tready;
        grant          = 2'b10;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  // Next owner: held mid-packet, re-arbitrated with the updated last owner on tlast accept.
  always_comb begin
    st_nxt_s = st_r;
    lg_nxt_s = lg_r;
    case (st_r)
      IDLE: begin
        st_nxt_s = arb(s0_axis_tvalid, s1_axis_tvalid, lg_r);
      end
      G0: begin
        if (pkt_end_s) begin
          lg_nxt_s = 1'b0;
          st_nxt_s = arb(s0_axis_tvalid, s1_axis_tvalid, 1'b0);
        end else begin
          st_nxt_s = G0;
        end
      end
      G1: begin
        if (pkt_end_s) begin
          lg_nxt_s = 1'b1;
          st_nxt_s = arb(s0_axis_tvalid, s1_axis_tvalid, 1'b1);
        end else begin
          st_nxt_s = G1;
        end
      end
      default: begin
        st_nxt_s = IDLE;
      end
    endcase
  end

  // Owner and last-owner registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_r <= IDLE;
      lg_r <= 1'b1;
    end else begin
      st_r <= st_nxt_s;
      lg_r <= lg_nxt_s;
    end
  end

`ifdef ARB_STATS_EN
  // Per-source packet counters; they wrap naturally at 32 bits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (pkt_end_s && (st_r == G0)) begin
      pkt_cnt0 <= pkt_cnt0 + 32'd1;
    end else if (pkt_end_s && (st_r == G1)) begin
      pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end else begin
      pkt_cnt0 <= pkt_cnt0;
      pkt_cnt1 <= pkt_cnt1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_addone_arbiter.sv
// Scoreboard bench for axis_addone_arbiter: packet-level round-robin model feeds an expected-beat queue.
// Define ARB_STATS_EN for both bench and RTL to exercise the packet counters.
module tb_axis_addone_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        dest;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [3:0]  s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic        s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic        s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic        s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic        m_axis_tdest;
  logic [1:0]  grant;
`ifdef ARB_STATS_EN
  logic [31:0] pkt_cnt0, pkt_cnt1;
`endif

  axis_addone_arbiter #(.DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdest(m_axis_tdest),
    .grant(grant)
`ifdef ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  int    tests = 0;
  int    fails = 0;
  int    nacc  = 0;
  beat_t q0[$], q1[$], exp_q[$], st0[$], st1[$];
  int    len0[$], len1[$];
  logic  rdy_q[$];
  bit    rand_rdy;
  bit    acc0, acc1;
  bit    last_owner;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
    chk({tag, "_m_tkeep_tlast_tdest"}, 64'({m_axis_tkeep, m_axis_tlast, m_axis_tdest}), 64'd0);
    chk({tag, "_treadys"}, 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
`ifdef ARB_STATS_EN
    chk({tag, "_pkt_cnts"}, {pkt_cnt0, pkt_cnt1}, 64'd0);
`endif
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); exp_q.delete(); st0.delete(); st1.delete();
    len0.delete(); len1.delete(); rdy_q.delete();
    acc0 = 1'b0; acc1 = 1'b0; rand_rdy = 1'b0; last_owner = 1'b1; nacc = 0;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = 32'd0; s0_axis_tkeep = 4'd0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = 32'd0; s1_axis_tkeep = 4'd0; s1_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    clear_all();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Stage one packet for a source (not yet visible to the driver).
  task automatic stage(input bit src, input int n, input logic [31:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = rnd ? $urandom : base + 32'(i) * 32'h04040404;
      b.keep = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
      b.last = (i == n - 1);
      b.dest = src;
      if (src) st1.push_back(b); else st0.push_back(b);
    end
    if (src) len1.push_back(n); else len0.push_back(n);
  endtask

  // Reference model: whole packets, alternating while both sides have work, starting with !last_owner.
  task automatic launch();
    bit pick;
    int n;
    beat_t b;
    while (len0.size() > 0 || len1.size() > 0) begin
      if (len0.size() > 0 && len1.size() > 0) pick = !last_owner;
      else pick = (len0.size() > 0) ? 1'b0 : 1'b1;
      last_owner = pick;
      n = pick ? len1.pop_front() : len0.pop_front();
      for (int i = 0; i < n; i++) begin
        b = pick ? st1.pop_front() : st0.pop_front();
        exp_q.push_back(b);
        if (pick) q1.push_back(b); else q0.push_back(b);
      end
    end
  endtask

  // One clock of stimulus: drive at negedge, record handshakes 1 ns later.
  task automatic step();
    @(negedge aclk);
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    s0_axis_tvalid = (q0.size() > 0);
    s0_axis_tdata  = (q0.size() > 0) ? q0[0].data : 32'd0;
    s0_axis_tkeep  = (q0.size() > 0) ? q0[0].keep : 4'd0;
    s0_axis_tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    s1_axis_tvalid = (q1.size() > 0);
    s1_axis_tdata  = (q1.size() > 0) ? q1[0].data : 32'd0;
    s1_axis_tkeep  = (q1.size() > 0) ? q1[0].keep : 4'd0;
    s1_axis_tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
    if (rdy_q.size() > 0) m_axis_tready = rdy_q.pop_front();
    else if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    else m_axis_tready = 1'b1;
    #1;
    acc0 = s0_axis_tvalid & s0_axis_tready;
    acc1 = s1_axis_tvalid & s1_axis_tready;
    if (m_axis_tvalid && m_axis_tready) nacc++;
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(q0.size() + q1.size() + exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the expected queue on every accepted beat and checks grant consistency.
  initial begin
    beat_t e;
    beat_t prev;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (aresetn !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        chk("grant_consistency", 64'((grant != 2'b11) &&
            !(grant == 2'b01 && s1_axis_tready) && !(grant == 2'b10 && s0_axis_tready) &&
            !(m_axis_tvalid && (m_axis_tdest != (grant == 2'b10)))), 64'd1);
        if (prev_stall)
          chk("stall_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}),
              64'({1'b1, prev}));
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}), 64'(e));
          end
        end
        prev_stall = m_axis_tvalid & !m_axis_tready;
        prev = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest};
      end
    end
  end

  initial begin
    aresetn = 1'b0;
    clear_all();
    repeat (2) @(negedge aclk);
    #1;
    check_zero("reset");
    aresetn = 1'b1;

    // Single requester, 4 beats: one bubble, then one beat per cycle on tdest 0.
    do_reset();
    stage(1'b0, 4, 32'h03020100, 1'b0);
    launch();
    step();
    chk("single_bubble", 64'({m_axis_tvalid, grant}), 64'd0);
    step();
    chk("single_first_beat", 64'({m_axis_tvalid, grant, m_axis_tdest}), 64'b1010);
    repeat (3) step();
    chk("single_throughput", 64'(nacc), 64'd4);
    run_until_empty("single", 20);

    // Simultaneous 2-beat packets: s0 then s1 with no bubble.
    do_reset();
    stage(1'b0, 2, 32'h10000000, 1'b0);
    stage(1'b1, 2, 32'h20000000, 1'b0);
    launch();
    repeat (5) step();
    chk("simul_no_bubble", 64'(nacc), 64'd4);
    run_until_empty("simul", 20);

    // Fairness: three single-beat packets each, alternating 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      stage(1'b0, 1, 32'hA0000000 + 32'(i), 1'b0);
      stage(1'b1, 1, 32'hB0000000 + 32'(i), 1'b0);
    end
    launch();
    repeat (7) step();
    chk("fair_no_bubble", 64'(nacc), 64'd6);
    run_until_empty("fair", 20);

    // Mid-packet lock: s1 shows up during beat 2 of s0 while tready toggles.
    do_reset();
    stage(1'b0, 4, 32'hC0C0C000, 1'b0);
    launch();
    repeat (2) step();
    stage(1'b1, 2, 32'hD0D0D000, 1'b0);
    launch();
    rdy_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    step();
    step();
    chk("lock_stall_grant", 64'({grant, s1_axis_tready}), 64'b010);
    run_until_empty("lock", 30);

    // Reset mid-packet: outputs drop at once, then only s1 is granted after one cycle.
    do_reset();
    stage(1'b0, 4, 32'hE0E0E000, 1'b0);
    launch();
    repeat (3) step();
    aresetn = 1'b0;
    #1;
    check_zero("midreset");
    clear_all();
    @(negedge aclk);
    aresetn = 1'b1;
    stage(1'b1, 2, 32'hF0F0F000, 1'b0);
    launch();
    step();
    chk("midreset_idle_first", 64'(grant), 64'd0);
    step();
    chk("midreset_s1_grant", 64'(grant), 64'b10);
    run_until_empty("midreset", 20);

    // Randomized packets, lengths, keeps and back-pressure.
    for (int r = 0; r < 20; r++) begin
      int n0, n1;
      do_reset();
      rand_rdy = 1'b1;
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      for (int i = 0; i < n0; i++) stage(1'b0, $urandom_range(1, 4), 32'd0, 1'b1);
      for (int i = 0; i < n1; i++) stage(1'b1, $urandom_range(1, 4), 32'd0, 1'b1);
      launch();
      run_until_empty("random", 500);
    end

`ifdef ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 256; i++) stage(1'b0, 1, 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) stage(1'b1, 1, 32'h55000000 + 32'(i), 1'b0);
    launch();
    run_until_empty("stats", 1000);
    chk("pkt_cnt0", 64'(pkt_cnt0), 64'd256);
    chk("pkt_cnt1", 64'(pkt_cnt1), 64'd3);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_zero("stats_reset");
    @(negedge aclk);
    aresetn = 1'b1;
`endif

    repeat (2) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
